ax_decision_unit: RTL and testbench
===================================

Name: ax_decision_unit

Overview:
- Consumes the approximation configuration constants (AX level width, LFSR width, LFSR seed) and produces per-instruction "approximate / do not approximate" decisions for the front-end.
- Sits between the approximation-level CSR write path and the fetch/branch-prediction lanes that consult the AxBTB.
- Holds a programmable AX level register and a Fibonacci LFSR.
- Each valid request consumes one pseudo-random sample. The decision is returned one cycle later.

Parameters:
- REQ_WIDTH, 4 (CONF_FETCH_WIDTH): number of request lanes per cycle.
- AX_LEVEL_WIDTH, 5 (CONF_AX_LEVEL_WIDTH): width of the AX level and of the compared random slice.
- LFSR_WIDTH, 32 (CONF_LFSR_WIDTH): LFSR state width. Must be greater than AX_LEVEL_WIDTH; elaboration error otherwise.
- LFSR_SEED, 32'h1010 (CONF_LFSR_SEED): LFSR reset and reseed value.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold all state and outputs; ignore requests and reseed
- flush  in  1  drop the in-flight response
- levelWe  in  1  write AX level
- levelIn  in  AX_LEVEL_WIDTH  new AX level
- reseed  in  1  reload LFSR with LFSR_SEED
- reqValid  in  REQ_WIDTH  per-lane request valid
- respValid  out  REQ_WIDTH  per-lane response valid
- respApprox  out  REQ_WIDTH  per-lane decision (1 = approximate)
- axLevel  out  AX_LEVEL_WIDTH  current level register

Behaviour:
- Reset (asynchronous, active-high):
  - LFSR = LFSR_SEED; axLevel = 0.
  - respValid = 0; respApprox = 0.
- LFSR step:
  - Taps x^32+x^22+x^2+x+1; fb = s[31]^s[21]^s[1]^s[0]; next = {s[30:0], fb}.
  - For other widths, use the standard maximal-length tap table held in the package.
- Per-cycle sampling:
  - Let k = popcount(reqValid).
  - The j-th valid lane in ascending lane order uses sample S_j, the current state advanced j steps (S_0 = current state).
  - At the clock edge the state becomes S_k. With k = 0 the state is unchanged.
- Decision:
  - approx = (S_j[AX_LEVEL_WIDTH-1:0] < axLevel), unsigned compare.
  - Level 0 never approximates. Level 2^W-1 approximates with probability (2^W-1)/2^W.
- Latency:
  - Request in cycle N gives respValid/respApprox registered at N+1.
  - respApprox is 0 on lanes whose respValid is 0.
- Stall:
  - LFSR, level and output registers hold.
  - Requests, levelWe and reseed are ignored.
- Flush:
  - Takes priority over new requests in the same cycle: respValid becomes 0 at the next edge.
  - The LFSR still advances by k. There is no rewind.
  - Flush and stall together: flush wins for respValid only.
- Level write:
  - Takes effect at the next edge.
  - A request in the same cycle compares against the old level.
- Reseed:
  - LFSR = LFSR_SEED at the next edge, overriding the advance.
  - Same-cycle requests use the pre-reseed samples.
- Lock-up guard: if the next state would be all zeros, load 1 instead.
- Reset mid-operation clears in-flight responses immediately (asynchronous).

Optional Feature:
- Macro: RSD_AX_DECISION_STAT_EN.
- When defined:
  - Adds outputs statReqCount[31:0] and statApproxCount[31:0].
  - Counters increment by the number of delivered valid responses and delivered approx=1 responses. Flushed or stalled responses are not counted.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package (next to the configuration constants):
  - AxLevelPath typedef (logic [AX_LEVEL_WIDTH-1:0]).
  - LfsrPath typedef.
  - Tap-mask constant table indexed by width.
  - AxDecisionResp struct {valid, approx}.
- One natural sub-module, ax_lfsr_multistep: a combinational function of (state, count) that outputs S_0..S_REQ_WIDTH and the next state, including the lock-up guard.
- The top module holds the registers, compare and control.

Test Plan:
- Reset, levelWe=1/levelIn=17, then reqValid=0001 → response next cycle respValid=0001, respApprox=0001 (sample 0x1010, low5=16 < 17).
- Next cycle reqValid=0001 → sample 0x2020, low5=0 → approx=1. Then reset, level=16, one request → approx=0 (16 < 16 false).
- Level=0, reqValid=1111 for 100 cycles → all respApprox=0, respValid=1111 each cycle, and the LFSR advances 4 per cycle (check against the reference model).
- reqValid=1010 from reset, level=17 → lane1 uses S_0=0x1010 (approx=1), lane3 uses S_1=0x2020 (approx=1). State after the edge = 0x4040.
- stall=1 with reqValid=1111 for 3 cycles → outputs and LFSR unchanged. Then flush with reqValid=0011 → respValid=0000 next cycle, LFSR advanced 2.
- levelWe and request in the same cycle (old=0, new=31) → response approx=0. reseed after 10 requests → next sample equals 0x1010.

Source files
------------

// File: rtl/ax_decision_unit_pkg.sv
// Configuration constants, shared types and the maximal-length LFSR tap table
// for the approximation decision unit.
package ax_decision_unit_pkg;

    localparam int CONF_FETCH_WIDTH    = 4;
    localparam int CONF_AX_LEVEL_WIDTH = 5;
    localparam int CONF_LFSR_WIDTH     = 32;
    localparam logic [CONF_LFSR_WIDTH-1:0] CONF_LFSR_SEED = 32'h0000_1010;

    typedef logic [CONF_AX_LEVEL_WIDTH-1:0] AxLevelPath;
    typedef logic [CONF_LFSR_WIDTH-1:0]     LfsrPath;

    typedef struct packed {
        logic valid;
        logic approx;
    } AxDecisionResp;

    localparam int LFSR_MIN_WIDTH = 2;
    localparam int LFSR_MAX_WIDTH = 32;

    // Bit i set means tap on state bit i (polynomial term x^(i+1)); indexed by width.
    localparam logic [LFSR_MAX_WIDTH-1:0] LFSR_TAP_TABLE [0:LFSR_MAX_WIDTH] = '{
        32'h0000_0000, 32'h0000_0000, 32'h0000_0003, 32'h0000_0006,
        32'h0000_000C, 32'h0000_0014, 32'h0000_0030, 32'h0000_0060,
        32'h0000_00B8, 32'h0000_0110, 32'h0000_0240, 32'h0000_0500,
        32'h0000_0829, 32'h0000_100D, 32'h0000_2015, 32'h0000_6000,
        32'h0000_D008, 32'h0001_2000, 32'h0002_0400, 32'h0004_0023,
        32'h0009_0000, 32'h0014_0000, 32'h0030_0000, 32'h0042_0000,
        32'h00E1_0000, 32'h0120_0000, 32'h0200_0023, 32'h0400_0013,
        32'h0900_0000, 32'h1400_0000, 32'h2000_0029, 32'h4800_0000,
        32'h8020_0003
    };

    function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_tap_mask(input int width);
        if (width >= LFSR_MIN_WIDTH && width <= LFSR_MAX_WIDTH) begin
            return LFSR_TAP_TABLE[width];
        end
        return '0;
    endfunction

endpackage

// File: rtl/ax_decision_unit_lfsr_multistep.sv
// Combinational multi-step Fibonacci LFSR: exposes S_0..S_STEPS and the state
// advanced by 'count' steps, with an all-zero lock-up guard on the next state.
module ax_lfsr_multistep
    import ax_decision_unit_pkg::*;
#(
    parameter int LFSR_WIDTH = CONF_LFSR_WIDTH,
    parameter int STEPS      = CONF_FETCH_WIDTH,
    parameter int CNT_WIDTH  = $clog2(STEPS + 1)
) (
    input  logic [LFSR_WIDTH-1:0]            state,
    input  logic [CNT_WIDTH-1:0]             count,
    output logic [STEPS:0][LFSR_WIDTH-1:0]   samples,
    output logic [LFSR_WIDTH-1:0]            next_state
);

    localparam logic [LFSR_WIDTH-1:0] TAP_MASK = LFSR_WIDTH'(lfsr_tap_mask(LFSR_WIDTH));

    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
        return {s[LFSR_WIDTH-2:0], ^(s & TAP_MASK)};
    endfunction

    logic [LFSR_WIDTH-1:0] walk;
    logic [LFSR_WIDTH-1:0] selected;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        walk     = state;
        selected = state;
        samples  = '0;
        for (int j = 0; j <= STEPS; j++) begin
            samples[j] = walk;
            if (count == CNT_WIDTH'(j)) begin
                selected = walk;
            end
            walk = lfsr_step(walk);
        end
        next_state = (selected == '0) ? LFSR_WIDTH'(1) : selected;
    end

endmodule

// File: rtl/ax_decision_unit.sv
// Approximation decision unit: AX level register, multi-lane LFSR sampling and
// registered per-lane decisions. Optional statistics counters: RSD_AX_DECISION_STAT_EN.
module ax_decision_unit
    import ax_decision_unit_pkg::*;
#(
    parameter int REQ_WIDTH      = CONF_FETCH_WIDTH,
    parameter int AX_LEVEL_WIDTH = CONF_AX_LEVEL_WIDTH,
    parameter int LFSR_WIDTH     = CONF_LFSR_WIDTH,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = LFSR_WIDTH'(CONF_LFSR_SEED)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      levelWe,
    input  logic [AX_LEVEL_WIDTH-1:0] levelIn,
    input  logic                      reseed,
    input  logic [REQ_WIDTH-1:0]      reqValid,
    output logic [REQ_WIDTH-1:0]      respValid,
    output logic [REQ_WIDTH-1:0]      respApprox,
    output logic [AX_LEVEL_WIDTH-1:0] axLevel
`ifdef RSD_AX_DECISION_STAT_EN
    ,
    output logic [31:0]               statReqCount,
    output logic [31:0]               statApproxCount
`endif
);

    localparam int CNT_WIDTH = $clog2(REQ_WIDTH + 1);

    if (LFSR_WIDTH <= AX_LEVEL_WIDTH || LFSR_WIDTH > LFSR_MAX_WIDTH
        || LFSR_WIDTH < LFSR_MIN_WIDTH) begin : g_bad_lfsr_width
        $error("ax_decision_unit: LFSR_WIDTH must exceed AX_LEVEL_WIDTH and lie in the tap table");
    end

    logic [LFSR_WIDTH-1:0]             lfsr_q, lfsr_d;
    logic [AX_LEVEL_WIDTH-1:0]         ax_level_q, ax_level_d;
    AxDecisionResp [REQ_WIDTH-1:0]     resp_q, resp_d;

    logic [CNT_WIDTH-1:0]              req_count;
    logic [CNT_WIDTH-1:0]              lane_rank;
    logic [REQ_WIDTH-1:0]              lane_approx;
    logic [REQ_WIDTH:0][LFSR_WIDTH-1:0] samples;
    logic [LFSR_WIDTH-1:0]             advanced_state;

    ax_lfsr_multistep #(
        .LFSR_WIDTH (LFSR_WIDTH),
        .STEPS      (REQ_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_lfsr_multistep (
        .state      (lfsr_q),
        .count      (req_count),
        .samples    (samples),
        .next_state (advanced_state)
    );

    // The j-th valid lane (ascending) consumes sample S_j.
    always_comb begin
        req_count   = CNT_WIDTH'($countones(reqValid));
        lane_rank   = '0;
        lane_approx = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (reqValid[i]) begin
                lane_approx[i] = (samples[lane_rank][AX_LEVEL_WIDTH-1:0] < ax_level_q);
                lane_rank      = lane_rank + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        lfsr_d     = lfsr_q;
        ax_level_d = ax_level_q;
        resp_d     = resp_q;
        if (!stall) begin
            lfsr_d = reseed ? LFSR_SEED : advanced_state;
            if (levelWe) begin
                ax_level_d = levelIn;
            end
            for (int i = 0; i < REQ_WIDTH; i++) begin
                resp_d[i].valid  = reqValid[i];
                resp_d[i].approx = lane_approx[i];
            end
        end
        if (flush) begin
            resp_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q     <= LFSR_SEED;
            ax_level_q <= '0;
            resp_q     <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            ax_level_q <= ax_level_d;
            resp_q     <= resp_d;
        end
    end

    always_comb begin
        respValid  = '0;
        respApprox = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            respValid[i]  = resp_q[i].valid;
            respApprox[i] = resp_q[i].approx;
        end
        axLevel = ax_level_q;
    end

    // Upper sample bits and S_REQ_WIDTH only feed the state chain; not consumed here.
    logic unused_sample_bits;
    assign unused_sample_bits = ^samples;

`ifdef RSD_AX_DECISION_STAT_EN
    logic [31:0] stat_req_q, stat_req_d;
    logic [31:0] stat_approx_q, stat_approx_d;

    function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [CNT_WIDTH-1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, acc} + 33'(inc);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Only responses that actually land in the output register are counted.
    always_comb begin
        stat_req_d    = stat_req_q;
        stat_approx_d = stat_approx_q;
        if (!stall && !flush) begin
            stat_req_d    = sat_add(stat_req_q, req_count);
            stat_approx_d = sat_add(stat_approx_q, CNT_WIDTH'($countones(lane_approx)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_req_q    <= '0;
            stat_approx_q <= '0;
        end else begin
            stat_req_q    <= stat_req_d;
            stat_approx_q <= stat_approx_d;
        end
    end

    assign statReqCount    = stat_req_q;
    assign statApproxCount = stat_approx_q;
`endif

    a_approx_implies_valid: assert property (@(posedge clk) disable iff (rst)
        (respApprox & ~respValid) == '0);
    a_lfsr_never_zero: assert property (@(posedge clk) disable iff (rst)
        lfsr_q != '0);

endmodule

// File: tb/tb_ax_decision_unit.sv
// Self-checking bench for ax_decision_unit: directed scenarios plus randomized
// traffic against a behavioural model of the sampling/decision rules.
`timescale 1ns/1ps
module tb_ax_decision_unit;
    import ax_decision_unit_pkg::*;

    localparam logic [31:0] SEED = 32'h0000_1010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0, flush = 1'b0, levelWe = 1'b0, reseed = 1'b0;
    logic [4:0] levelIn = '0;
    logic [3:0] reqValid = '0;
    logic [3:0] respValid, respApprox;
    logic [4:0] axLevel;
`ifdef RSD_AX_DECISION_STAT_EN
    logic [31:0] statReqCount, statApproxCount;
`endif

    always #5 clk = ~clk;

    ax_decision_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .levelWe    (levelWe),
        .levelIn    (levelIn),
        .reseed     (reseed),
        .reqValid   (reqValid),
        .respValid  (respValid),
        .respApprox (respApprox),
        .axLevel    (axLevel)
`ifdef RSD_AX_DECISION_STAT_EN
        ,
        .statReqCount    (statReqCount),
        .statApproxCount (statApproxCount)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_lfsr;
    logic [4:0]  m_level;
    logic [3:0]  m_rv, m_ra;
    longint      m_req_cnt, m_apx_cnt;

    function automatic logic [31:0] ref_next(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; m_level = '0; m_rv = '0; m_ra = '0;
        m_req_cnt = 0; m_apx_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 0; flush = 0; levelWe = 0; levelIn = '0; reseed = 0; reqValid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drive one cycle of inputs, advance the model, return #1 after the edge.
    task automatic cycle(input logic st, input logic fl, input logic lwe,
                         input logic [4:0] lin, input logic rs, input logic [3:0] rv);
        logic [31:0] s;
        logic [3:0]  apx;
        int          n;
        stall = st; flush = fl; levelWe = lwe; levelIn = lin; reseed = rs; reqValid = rv;
        s = m_lfsr; apx = '0; n = 0;
        if (!st) begin
            for (int i = 0; i < 4; i++) begin
                if (rv[i]) begin
                    apx[i] = (s[4:0] < m_level);
                    s = ref_next(s);
                    n++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (fl) begin
            m_rv = '0; m_ra = '0;
        end else if (!st) begin
            m_rv = rv; m_ra = apx;
        end
        if (!st) begin
            if (!fl) begin
                m_req_cnt += n;
                m_apx_cnt += $countones(apx);
            end
            m_lfsr = rs ? SEED : ((s == 32'd0) ? 32'd1 : s);
            if (lwe) m_level = lin;
        end
        stall = 0; flush = 0; levelWe = 0; levelIn = '0; reseed = 0; reqValid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (respValid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", respValid); end
        checks++; if (respApprox !== 4'b0000) begin errors++; $display("FAIL reset_approx: got %b expected 0000", respApprox); end
        checks++; if (axLevel !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", axLevel); end
        checks++; if (dut.lfsr_q !== SEED) begin errors++; $display("FAIL reset_lfsr: got %h expected %h", dut.lfsr_q, SEED); end
        do_reset();
    endtask

    task automatic test_level_compare();
        do_reset();
        cycle(0, 0, 1, 5'd17, 0, 4'b0000);
        checks++; if (axLevel !== 5'd17) begin errors++; $display("FAIL level_write: got %0d expected 17", axLevel); end
        cycle(0, 0, 0, 5'd0, 0, 4'b0001);
        checks++; if (respValid !== 4'b0001 || respApprox !== 4'b0001) begin
            errors++; $display("FAIL lvl17_first: got v=%b a=%b expected v=0001 a=0001", respValid, respApprox); end
        cycle(0, 0, 0, 5'd0, 0, 4'b0001);
        checks++; if (respApprox !== 4'b0001) begin errors++; $display("FAIL lvl17_second: got %b expected 0001", respApprox); end
        do_reset();
        cycle(0, 0, 1, 5'd16, 0, 4'b0000);
        cycle(0, 0, 0, 5'd0, 0, 4'b0001);
        checks++; if (respValid !== 4'b0001 || respApprox !== 4'b0000) begin
            errors++; $display("FAIL lvl16_equal: got v=%b a=%b expected v=0001 a=0000", respValid, respApprox); end
    endtask

    task automatic test_level0_burst();
        do_reset();
        for (int c = 0; c < 100; c++) begin
            cycle(0, 0, 0, 5'd0, 0, 4'b1111);
            checks++; if (respValid !== 4'b1111 || respApprox !== 4'b0000) begin
                errors++; $display("FAIL lvl0_burst c=%0d: got v=%b a=%b expected v=1111 a=0000", c, respValid, respApprox); end
            checks++; if (dut.lfsr_q !== m_lfsr) begin
                errors++; $display("FAIL lvl0_lfsr c=%0d: got %h expected %h", c, dut.lfsr_q, m_lfsr); end
        end
    endtask

    task automatic test_sparse_lanes();
        do_reset();
        cycle(0, 0, 1, 5'd17, 0, 4'b0000);
        cycle(0, 0, 0, 5'd0, 0, 4'b1010);
        checks++; if (respValid !== 4'b1010 || respApprox !== 4'b1010) begin
            errors++; $display("FAIL sparse_lanes: got v=%b a=%b expected v=1010 a=1010", respValid, respApprox); end
        checks++; if (dut.lfsr_q !== 32'h0000_4040) begin
            errors++; $display("FAIL sparse_lfsr: got %h expected 00004040", dut.lfsr_q); end
    endtask

    task automatic test_stall_flush();
        logic [3:0]  hold_v, hold_a;
        logic [31:0] hold_lfsr, expect_lfsr;
        cycle(0, 0, 1, 5'd20, 0, 4'b0110);
        hold_v = m_rv; hold_a = m_ra; hold_lfsr = m_lfsr;
        for (int c = 0; c < 3; c++) begin
            cycle(1, 0, 1, 5'd3, 1, 4'b1111);
            checks++; if (respValid !== hold_v || respApprox !== hold_a) begin
                errors++; $display("FAIL stall_hold c=%0d: got v=%b a=%b expected v=%b a=%b", c, respValid, respApprox, hold_v, hold_a); end
            checks++; if (dut.lfsr_q !== hold_lfsr || axLevel !== 5'd20) begin
                errors++; $display("FAIL stall_state c=%0d: got lfsr=%h lvl=%0d expected lfsr=%h lvl=20", c, dut.lfsr_q, axLevel, hold_lfsr); end
        end
        expect_lfsr = ref_next(ref_next(hold_lfsr));
        cycle(0, 1, 0, 5'd0, 0, 4'b0011);
        checks++; if (respValid !== 4'b0000 || respApprox !== 4'b0000) begin
            errors++; $display("FAIL flush_drop: got v=%b a=%b expected v=0000 a=0000", respValid, respApprox); end
        checks++; if (dut.lfsr_q !== expect_lfsr) begin
            errors++; $display("FAIL flush_advance: got %h expected %h", dut.lfsr_q, expect_lfsr); end
        cycle(0, 0, 0, 5'd0, 0, 4'b1111);
        hold_lfsr = m_lfsr;
        cycle(1, 1, 0, 5'd0, 0, 4'b1111);
        checks++; if (respValid !== 4'b0000 || dut.lfsr_q !== hold_lfsr) begin
            errors++; $display("FAIL flush_stall: got v=%b lfsr=%h expected v=0000 lfsr=%h", respValid, dut.lfsr_q, hold_lfsr); end
    endtask

    task automatic test_level_same_cycle();
        do_reset();
        cycle(0, 0, 1, 5'd31, 0, 4'b0001);
        checks++; if (respValid !== 4'b0001 || respApprox !== 4'b0000) begin
            errors++; $display("FAIL lvl_same_cycle: got v=%b a=%b expected v=0001 a=0000", respValid, respApprox); end
        cycle(0, 0, 0, 5'd0, 0, 4'b0001);
        checks++; if (respApprox !== 4'b0001) begin
            errors++; $display("FAIL lvl_new_used: got %b expected 0001", respApprox); end
    endtask

    task automatic test_reseed();
        do_reset();
        cycle(0, 0, 1, 5'd17, 0, 4'b0000);
        for (int c = 0; c < 10; c++) cycle(0, 0, 0, 5'd0, 0, 4'b0001);
        cycle(0, 0, 0, 5'd0, 1, 4'b0000);
        checks++; if (dut.lfsr_q !== SEED) begin
            errors++; $display("FAIL reseed_state: got %h expected %h", dut.lfsr_q, SEED); end
        cycle(0, 0, 0, 5'd0, 0, 4'b0001);
        checks++; if (respApprox !== 4'b0001) begin
            errors++; $display("FAIL reseed_sample: got %b expected 0001", respApprox); end
        cycle(0, 0, 0, 5'd0, 1, 4'b0011);
        checks++; if (respValid !== m_rv || respApprox !== m_ra || dut.lfsr_q !== SEED) begin
            errors++; $display("FAIL reseed_same_cycle: got v=%b a=%b lfsr=%h expected v=%b a=%b lfsr=%h",
                respValid, respApprox, dut.lfsr_q, m_rv, m_ra, SEED); end
    endtask

    task automatic test_async_reset_midop();
        do_reset();
        cycle(0, 0, 1, 5'd31, 0, 4'b0000);
        cycle(0, 0, 0, 5'd0, 0, 4'b1111);
        #2 rst = 1'b1;
        #1;
        checks++; if (respValid !== 4'b0000 || respApprox !== 4'b0000 || axLevel !== 5'd0) begin
            errors++; $display("FAIL async_reset: got v=%b a=%b lvl=%0d expected all zero", respValid, respApprox, axLevel); end
        do_reset();
    endtask

    task automatic test_random();
        logic st, fl, lwe, rs;
        logic [4:0] lin;
        logic [3:0] rv;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            st  = ($urandom_range(0, 7) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            lwe = ($urandom_range(0, 7) == 0);
            rs  = ($urandom_range(0, 19) == 0);
            lin = 5'($urandom);
            rv  = 4'($urandom);
            cycle(st, fl, lwe, lin, rs, rv);
            checks++; if (respValid !== m_rv || respApprox !== m_ra) begin
                errors++; $display("FAIL random_resp c=%0d: got v=%b a=%b expected v=%b a=%b", c, respValid, respApprox, m_rv, m_ra); end
            checks++; if (dut.lfsr_q !== m_lfsr || axLevel !== m_level) begin
                errors++; $display("FAIL random_state c=%0d: got lfsr=%h lvl=%0d expected lfsr=%h lvl=%0d", c, dut.lfsr_q, axLevel, m_lfsr, m_level); end
        end
`ifdef RSD_AX_DECISION_STAT_EN
        checks++; if (statReqCount !== 32'(m_req_cnt) || statApproxCount !== 32'(m_apx_cnt)) begin
            errors++; $display("FAIL stat_counts: got req=%0d apx=%0d expected req=%0d apx=%0d",
                statReqCount, statApproxCount, m_req_cnt, m_apx_cnt); end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_level_compare();
        test_level0_burst();
        test_sparse_lanes();
        test_stall_flush();
        test_level_same_cycle();
        test_reseed();
        test_async_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
